mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage sitting between the execute stage and write-back. It registers the execute-stage bus and waits for the data SRAM response of any load or store issued upstream. Load data is extracted and sign/zero-extended by size and byte offset, and the result goes to write-back over a valid/allowin handshake. It also drops in-flight SRAM responses belonging to instructions flushed by write-back exceptions, ertn or refetch.

## Interface
Parameters: none.

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- es_to_ms_valid  in  1  execute stage presents a valid instruction
- es_to_ms_bus  in  80  {ex[79], ertn[78], refetch[77], mem_req[76], mem_we[75], ld_op[74:70] = {ld_b, ld_bu, ld_h, ld_hu, ld_w}, gr_we[69], dest[68:64], result[63:32], pc[31:0]}
  - mem_req = 1 means the request was accepted (addr_ok) in EXE
  - result[1:0] is the byte offset
- ms_allowin  out  1  stage can accept a new instruction this cycle
- ws_allowin  in  1  write-back can accept
- ms_to_ws_valid  out  1  valid instruction to write-back
- ms_to_ws_bus  out  73  {ex[72], ertn[71], refetch[70], gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
- data_sram_data_ok  in  1  one response beat (read data or write ack)
- data_sram_rdata  in  32  read data, valid with data_ok
- wb_flush  in  1  write-back exception / ertn / refetch this cycle
- mem_ex, mem_ertn, mem_refetch  out  1 each  corresponding bus bit AND ms_valid
- out_ms_valid  out  1  ms_valid, for hazard detection in decode
- ms_dest  out  5  dest if ms_valid & gr_we, else 0
- ms_load_pending  out  1  ms_valid & a load (any ld_op bit) & ~ms_ready_go; decode must stall, not bypass

## Operation
- State:
  - ms_valid
  - bus register (80 bits)
  - data_buf[31:0] and data_buf_valid
  - discard_cnt[1:0]
- ms_ready_go = ~mem_req | data_buf_valid | (data_ok & discard_cnt==0).
- ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
- ms_to_ws_valid = ms_valid & ms_ready_go.
- ms_valid update (priority order):
  - wb_flush → 0
  - else if ms_allowin → es_to_ms_valid
- Bus register loads when es_to_ms_valid & ms_allowin, regardless of wb_flush.
- Response steering: a data_ok with discard_cnt > 0 is dropped and discard_cnt decrements.
- Otherwise, a data_ok with ms_valid & mem_req & ~data_buf_valid:
  - captures rdata into data_buf and sets data_buf_valid, when not advancing this cycle
  - if the stage advances in the same cycle, rdata is used directly.
- data_buf_valid clears when the stage advances (ms_to_ws_valid & ws_allowin) or on wb_flush.
- Flush with outstanding response: outstanding = ms_valid & mem_req & ~data_buf_valid & ~(data_ok & discard_cnt==0). wb_flush & outstanding → discard_cnt + 1.
  - Simultaneous increment and decrement nets to zero change.
  - Saturates at 3.
- Load extraction, with off = result[1:0]:
  - byte = rdata byte at off
  - half = rdata[31:16] if off[1], else [15:0]
  - ld_b: sign-extend byte; ld_bu: zero-extend byte
  - ld_h: sign-extend half; ld_hu: zero-extend half
  - ld_w: full word
- final_result = loaded value if any ld_op bit and ex == 0; otherwise result. Stores and exception carriers pass result through.
- Source data for extraction: data_buf if data_buf_valid, else data_sram_rdata.

## Timing
- Reset values:
  - ms_valid = 0, data_buf_valid = 0, discard_cnt = 0, bus register = 0
  - hence all outputs 0 except ms_allowin = 1
- Non-memory instruction: 1 cycle in stage; visible to WB the cycle after acceptance.
- Memory instruction: leaves in the first cycle where a non-discarded data_ok arrives (combinational) or data_buf_valid holds, and ws_allowin = 1.
- data_ok while ws_allowin = 0: data buffered; the instruction leaves on a later cycle with no further data_ok needed.
- wb_flush takes effect on the next edge; the stage is empty the following cycle even if es_to_ms_valid was high.
- A data_ok in the same cycle as wb_flush for the current instruction is consumed; discard_cnt does not change.

## Test plan
- add, result 0x1234, ws_allowin = 1 → ms_to_ws_valid high one cycle later; final_result 0x1234; ms_allowin stays 1.
- ld_b with result[1:0] = 2, rdata 0x0080FF00, data_ok 3 cycles after entry → stalls 3 cycles with ms_load_pending = 1, then final_result 0xFFFFFF80; ld_bu same case gives 0x00000080.
- ld_h with off = 2, rdata 0x8001_7FFF → 0xFFFF8001; ld_hu → 0x00008001; ld_w → 0x80017FFF.
- data_ok with rdata 0xDEADBEEF while ws_allowin = 0 for 4 cycles → held; on release ld_w delivers 0xDEADBEEF; a second data_ok is not required.
- Load outstanding, wb_flush pulse → stage empty next cycle, discard_cnt = 1. A new load enters and its stale data_ok (0x11111111) is dropped. The next data_ok (0x22222222) completes the new load with 0x22222222.
- reset asserted mid-wait (asynchronous, between edges) → ms_valid, data_buf_valid and discard_cnt zero immediately; ms_allowin = 1.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute bus, waits for the data SRAM
// response of issued loads/stores, extends load data and hands results to write-back.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_to_ms_valid,
    input  logic [79:0] es_to_ms_bus,
    output logic        ms_allowin,
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [72:0] ms_to_ws_bus,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        wb_flush,
    output logic        mem_ex,
    output logic        mem_ertn,
    output logic        mem_refetch,
    output logic        out_ms_valid,
    output logic [4:0]  ms_dest,
    output logic        ms_load_pending
);

    logic        ms_valid_reg;
    logic [79:0] bus_reg;
    logic [31:0] data_buf_reg;
    logic        data_buf_valid_reg;
    logic [1:0]  discard_cnt_reg;

    logic        ms_valid_next;
    logic        data_buf_valid_next;
    logic [1:0]  discard_cnt_next;

    // Bus field decode
    logic        ex, ertn, refetch, mem_req, gr_we;
    logic [4:0]  ld_op, dest;
    logic [31:0] result, pc;
    logic        is_load;
    logic [1:0]  off;

    assign ex      = bus_reg[79];
    assign ertn    = bus_reg[78];
    assign refetch = bus_reg[77];
    assign mem_req = bus_reg[76];
    assign ld_op   = bus_reg[74:70];
    assign gr_we   = bus_reg[69];
    assign dest    = bus_reg[68:64];
    assign result  = bus_reg[63:32];
    assign pc      = bus_reg[31:0];
    assign is_load = |ld_op;
    assign off     = result[1:0];

    // A response only belongs to the current instruction once all stale ones are drained.
    logic resp_live;
    logic ms_ready_go;
    logic advance;
    logic capture;
    logic outstanding;
    logic cnt_inc, cnt_dec;

    assign resp_live      = data_sram_data_ok & (discard_cnt_reg == 2'd0);
    assign ms_ready_go    = ~mem_req | data_buf_valid_reg | resp_live;
    assign ms_allowin     = ~ms_valid_reg | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid_reg & ms_ready_go;
    assign advance        = ms_to_ws_valid & ws_allowin;
    assign capture        = resp_live & ms_valid_reg & mem_req & ~data_buf_valid_reg & ~advance;
    assign outstanding    = ms_valid_reg & mem_req & ~data_buf_valid_reg & ~resp_live;
    assign cnt_inc        = wb_flush & outstanding;
    assign cnt_dec        = data_sram_data_ok & (discard_cnt_reg != 2'd0);

    always_comb begin
        ms_valid_next = ms_valid_reg;
        if (wb_flush)
            ms_valid_next = 1'b0;
        else if (ms_allowin)
            ms_valid_next = es_to_ms_valid;
    end

    always_comb begin
        data_buf_valid_next = data_buf_valid_reg;
        if (wb_flush || advance)
            data_buf_valid_next = 1'b0;
        else if (capture)
            data_buf_valid_next = 1'b1;
    end

    always_comb begin
        discard_cnt_next = discard_cnt_reg;
        if (cnt_inc && !cnt_dec && discard_cnt_reg != 2'd3)
            discard_cnt_next = discard_cnt_reg + 2'd1;
        else if (cnt_dec && !cnt_inc)
            discard_cnt_next = discard_cnt_reg - 2'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_reg       <= 1'b0;
            bus_reg            <= '0;
            data_buf_reg       <= '0;
            data_buf_valid_reg <= 1'b0;
            discard_cnt_reg    <= 2'd0;
        end else begin
            ms_valid_reg       <= ms_valid_next;
            data_buf_valid_reg <= data_buf_valid_next;
            discard_cnt_reg    <= discard_cnt_next;
            if (es_to_ms_valid && ms_allowin)
                bus_reg <= es_to_ms_bus;
            if (capture)
                data_buf_reg <= data_sram_rdata;
        end
    end

    // Load data extraction
    logic [31:0] src_word;
    logic [7:0]  lane [4];
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;
    logic [31:0] final_result;

    assign src_word = data_buf_valid_reg ? data_buf_reg : data_sram_rdata;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = src_word[8*gi +: 8];
    end

    assign ld_byte = lane[off];
    assign ld_half = off[1] ? src_word[31:16] : src_word[15:0];

    always_comb begin
        load_val = src_word;
        if (ld_op[4])
            load_val = {{24{ld_byte[7]}}, ld_byte};
        else if (ld_op[3])
            load_val = {24'd0, ld_byte};
        else if (ld_op[2])
            load_val = {{16{ld_half[15]}}, ld_half};
        else if (ld_op[1])
            load_val = {16'd0, ld_half};
    end

    // Exception carriers never touched memory, so they forward result untouched.
    assign final_result = (is_load && !ex) ? load_val : result;

    assign ms_to_ws_bus    = {ex, ertn, refetch, gr_we, dest, final_result, pc};
    assign mem_ex          = ex & ms_valid_reg;
    assign mem_ertn        = ertn & ms_valid_reg;
    assign mem_refetch     = refetch & ms_valid_reg;
    assign out_ms_valid    = ms_valid_reg;
    assign ms_dest         = (ms_valid_reg && gr_we) ? dest : 5'd0;
    assign ms_load_pending = ms_valid_reg & is_load & ~ms_ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: handshake, load extension,
// response buffering, flush-discard of stale responses and asynchronous reset.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_to_ms_valid;
    logic [79:0] es_to_ms_bus;
    logic        ms_allowin;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [72:0] ms_to_ws_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        wb_flush;
    logic        mem_ex, mem_ertn, mem_refetch;
    logic        out_ms_valid;
    logic [4:0]  ms_dest;
    logic        ms_load_pending;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [4:0] LD_NONE = 5'b00000;
    localparam logic [4:0] LD_B    = 5'b10000;
    localparam logic [4:0] LD_BU   = 5'b01000;
    localparam logic [4:0] LD_H    = 5'b00100;
    localparam logic [4:0] LD_HU   = 5'b00010;
    localparam logic [4:0] LD_W    = 5'b00001;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .wb_flush          (wb_flush),
        .mem_ex            (mem_ex),
        .mem_ertn          (mem_ertn),
        .mem_refetch       (mem_refetch),
        .out_ms_valid      (out_ms_valid),
        .ms_dest           (ms_dest),
        .ms_load_pending   (ms_load_pending)
    );

    function automatic logic [79:0] mk(input logic ex, input logic ertn, input logic refetch,
                                       input logic mem_req, input logic mem_we, input logic [4:0] ld,
                                       input logic gr_we, input logic [4:0] dest,
                                       input logic [31:0] res, input logic [31:0] pc);
        return {ex, ertn, refetch, mem_req, mem_we, ld, gr_we, dest, res, pc};
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Load enters, stalls wait_n cycles, then completes on a live data_ok.
    task automatic run_load(input string tag, input logic [4:0] ld, input logic [31:0] res,
                            input logic [31:0] rdata, input logic [31:0] exp, input int wait_n);
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ld, 1'b1, 5'd7, res, 32'h0000_2000);
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        for (int i = 0; i < wait_n; i++) begin
            #1;
            chk({tag, "_pending"}, 80'(ms_load_pending), 80'd1);
            chk({tag, "_stall"}, 80'(ms_to_ws_valid), 80'd0);
            @(negedge clk);
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rdata;
        #1;
        chk({tag, "_valid"}, 80'(ms_to_ws_valid), 80'd1);
        chk({tag, "_result"}, 80'(ms_to_ws_bus[63:32]), 80'(exp));
        chk({tag, "_dest"}, 80'(ms_dest), 80'd7);
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        #1;
        chk({tag, "_empty"}, 80'(out_ms_valid), 80'd0);
    endtask

    initial begin
        reset             = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        ws_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        wb_flush          = 1'b0;
        #3;
        chk("rst_allowin", 80'(ms_allowin), 80'd1);
        chk("rst_to_ws_valid", 80'(ms_to_ws_valid), 80'd0);
        chk("rst_bus", 80'(ms_to_ws_bus), 80'd0);
        chk("rst_misc", 80'({mem_ex, mem_ertn, mem_refetch, out_ms_valid, ms_dest, ms_load_pending}), 80'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Non-memory instruction passes in one cycle
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LD_NONE, 1'b1, 5'd3, 32'h0000_1234, 32'h0000_0100);
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
        chk("add_valid", 80'(ms_to_ws_valid), 80'd1);
        chk("add_bus", 80'(ms_to_ws_bus), 80'({1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_1234, 32'h0000_0100}));
        chk("add_allowin", 80'(ms_allowin), 80'd1);
        chk("add_dest", 80'(ms_dest), 80'd3);
        @(negedge clk);
        #1;
        chk("add_gone", 80'(ms_to_ws_valid), 80'd0);

        // Load extension by size and offset
        run_load("ldb_off2", LD_B, 32'h0000_1002, 32'h0080_FF00, 32'hFFFF_FF80, 3);
        run_load("ldbu_off2", LD_BU, 32'h0000_1002, 32'h0080_FF00, 32'h0000_0080, 3);
        run_load("ldb_off1", LD_B, 32'h0000_1001, 32'h0080_FF00, 32'hFFFF_FFFF, 1);
        run_load("ldb_off0", LD_B, 32'h0000_1000, 32'h0080_FF00, 32'h0000_0000, 0);
        run_load("ldbu_off3", LD_BU, 32'h0000_1003, 32'hA580_FF00, 32'h0000_00A5, 1);
        run_load("ldh_off2", LD_H, 32'h0000_1002, 32'h8001_7FFF, 32'hFFFF_8001, 1);
        run_load("ldhu_off2", LD_HU, 32'h0000_1002, 32'h8001_7FFF, 32'h0000_8001, 1);
        run_load("ldh_off0", LD_H, 32'h0000_1000, 32'h8001_7FFF, 32'h0000_7FFF, 0);
        run_load("ldw", LD_W, 32'h0000_1000, 32'h8001_7FFF, 32'h8001_7FFF, 2);

        // Response arrives while write-back is blocked: buffered and held
        ws_allowin = 1'b0;
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, LD_W, 1'b1, 5'd9, 32'h0000_3000, 32'h0000_0200);
        @(negedge clk);
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        #1;
        chk("buf_first_allowin", 80'(ms_allowin), 80'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = 32'h0;
            #1;
            chk("buf_hold_valid", 80'(ms_to_ws_valid), 80'd1);
            chk("buf_hold_data", 80'(ms_to_ws_bus[63:32]), 80'(32'hDEAD_BEEF));
            chk("buf_hold_pending", 80'(ms_load_pending), 80'd0);
        end
        @(negedge clk);
        ws_allowin = 1'b1;
        #1;
        chk("buf_release_valid", 80'(ms_to_ws_valid), 80'd1);
        chk("buf_release_data", 80'(ms_to_ws_bus[63:32]), 80'(32'hDEAD_BEEF));
        chk("buf_release_allowin", 80'(ms_allowin), 80'd1);
        @(negedge clk);
        #1;
        chk("buf_gone", 80'(out_ms_valid), 80'd0);

        // Flush with an outstanding response: the next response is stale
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, LD_W, 1'b1, 5'd4, 32'h0000_4000, 32'h0000_0300);
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        wb_flush       = 1'b1;
        @(negedge clk);
        wb_flush = 1'b0;
        #1;
        chk("flush_empty", 80'(out_ms_valid), 80'd0);
        chk("flush_allowin", 80'(ms_allowin), 80'd1);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, LD_W, 1'b1, 5'd5, 32'h0000_5000, 32'h0000_0304);
        @(negedge clk);
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_1111;
        #1;
        chk("stale_dropped", 80'(ms_to_ws_valid), 80'd0);
        chk("stale_pending", 80'(ms_load_pending), 80'd1);
        @(negedge clk);
        data_sram_rdata = 32'h2222_2222;
        #1;
        chk("fresh_valid", 80'(ms_to_ws_valid), 80'd1);
        chk("fresh_data", 80'(ms_to_ws_bus[63:32]), 80'(32'h2222_2222));
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        #1;
        chk("fresh_gone", 80'(out_ms_valid), 80'd0);

        // Response in the flush cycle is consumed; nothing left to discard
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, LD_W, 1'b1, 5'd6, 32'h0000_6000, 32'h0000_0400);
        @(negedge clk);
        es_to_ms_valid    = 1'b0;
        wb_flush          = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h5555_5555;
        @(negedge clk);
        wb_flush          = 1'b0;
        data_sram_data_ok = 1'b0;
        #1;
        chk("flushok_empty", 80'(out_ms_valid), 80'd0);
        run_load("flushok_next", LD_W, 32'h0000_7000, 32'h4444_4444, 32'h4444_4444, 0);

        // Flush while a new instruction is offered: stage still empties
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LD_NONE, 1'b1, 5'd2, 32'h0000_0042, 32'h0000_0500);
        @(negedge clk);
        wb_flush     = 1'b1;
        es_to_ms_bus = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LD_NONE, 1'b1, 5'd8, 32'h0000_0043, 32'h0000_0504);
        @(negedge clk);
        wb_flush       = 1'b0;
        es_to_ms_valid = 1'b0;
        #1;
        chk("flush_offer_empty", 80'(out_ms_valid), 80'd0);
        chk("flush_offer_dest", 80'(ms_dest), 80'd0);

        // Exception carrier on a load passes result through
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, LD_W, 1'b0, 5'd1, 32'h0000_BAD0, 32'h0000_0600);
        @(negedge clk);
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h9999_9999;
        #1;
        chk("ex_valid", 80'(ms_to_ws_valid), 80'd1);
        chk("ex_flags", 80'({mem_ex, mem_ertn, mem_refetch}), 80'(3'b101));
        chk("ex_result", 80'(ms_to_ws_bus[63:32]), 80'(32'h0000_BAD0));
        chk("ex_nodest", 80'(ms_dest), 80'd0);
        @(negedge clk);
        data_sram_rdata = 32'h0;

        // Asynchronous reset mid-wait with a pending discard
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, LD_W, 1'b1, 5'd10, 32'h0000_8000, 32'h0000_0700);
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        wb_flush       = 1'b1;
        @(negedge clk);
        wb_flush       = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, LD_W, 1'b1, 5'd11, 32'h0000_8004, 32'h0000_0704);
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
        chk("prereset_pending", 80'(ms_load_pending), 80'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 80'(out_ms_valid), 80'd0);
        chk("async_rst_allowin", 80'(ms_allowin), 80'd1);
        chk("async_rst_bus", 80'(ms_to_ws_bus), 80'd0);
        chk("async_rst_pending", 80'(ms_load_pending), 80'd0);
        @(negedge clk);
        reset = 1'b0;
        run_load("postreset", LD_W, 32'h0000_9000, 32'h3333_3333, 32'h3333_3333, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
